bp_cfg_commit_ctrl: RTL and testbench

Runtime configuration controller for multi-core BlackParrot tiles. It holds a shadow and an active copy of each core's configuration selection: the config index into the compiled config table, the memory-NoC DID, and the core coordinate. Host writes land in the shadow copy. A commit freezes only the affected cores, waits for them to drain, applies the new values atomically and releases the cores. It sits between the host register interface and the per-core config-bus drivers.

---
 rtl/bp_cfg_commit_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_bp_cfg_commit_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bp_cfg_commit_ctrl.sv
// Per-core shadow/active configuration with a freeze-drain-apply commit sequence.
// Optional drain timeout and ABORT path: define BP_CFG_COMMIT_TIMEOUT_EN.
module bp_cfg_commit_ctrl #(
   parameter int num_ch_p      = 4,
   parameter int lg_max_cfgs_p = 3,
   parameter int num_cfgs_p    = 3,
   parameter int did_width_p   = 19,
   parameter int cord_width_p  = 8,
   parameter int timeout_p     = 1023
) (
   input  logic                                clk_i,
   input  logic                                reset_n_i,
   input  logic                                w_v_i,
   output logic                                w_ready_o,
   input  logic [$clog2(num_ch_p)-1:0]         w_ch_i,
   input  logic [1:0]                          w_field_i,
   input  logic [31:0]                         w_data_i,
   input  logic [$clog2(num_ch_p)-1:0]         r_ch_i,
   input  logic [1:0]                          r_field_i,
   output logic [31:0]                         r_data_o,
   input  logic [num_ch_p-1:0]                 idle_i,
   output logic [num_ch_p-1:0]                 freeze_o,
   output logic [num_ch_p*lg_max_cfgs_p-1:0]   cfg_idx_o,
   output logic [num_ch_p*did_width_p-1:0]     did_o,
   output logic [num_ch_p*cord_width_p-1:0]    cord_o,
   output logic                                busy_o,
   output logic                                commit_done_o,
   output logic                                timeout_o,
   output logic                                err_o,
   output logic [2:0]                          dbg_state_o
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FREEZE = 3'd1,
      S_DRAIN  = 3'd2,
      S_APPLY  = 3'd3
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
      , S_ABORT = 3'd4
`endif
   } state_e;

   typedef struct packed {
      logic [lg_max_cfgs_p-1:0] idx;
      logic [did_width_p-1:0]   did;
      logic [cord_width_p-1:0]  cord;
   } cfg_t;

   function automatic cfg_t reset_cfg(input int ch);
      reset_cfg      = '0;
      reset_cfg.cord = cord_width_p'(ch);
   endfunction

   state_e              state_q, state_d;
   cfg_t                shadow_q [num_ch_p];
   cfg_t                shadow_d [num_ch_p];
   cfg_t                active_q [num_ch_p];
   cfg_t                active_d [num_ch_p];
   logic [num_ch_p-1:0] dirty_q, dirty_d;
   // freeze_q doubles as the commit mask: it is only written in FREEZE and on exit.
   logic [num_ch_p-1:0] freeze_q, freeze_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                wr_acc;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
   localparam int cnt_w_lp = $clog2(timeout_p + 1);
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic                timeout_q, timeout_d;
`endif

   // Handshake: a write transfers on any cycle where w_v_i && w_ready_o; the
   // writer must hold w_ch_i/w_field_i/w_data_i stable until then.
   assign wr_acc = w_v_i && (state_q == S_IDLE);

   always_comb begin
      state_d  = state_q;
      shadow_d = shadow_q;
      active_d = active_q;
      dirty_d  = dirty_q;
      freeze_d = freeze_q;
      done_d   = 1'b0;
      err_d    = err_q;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (wr_acc) begin
               if (w_field_i == 2'd3) begin
                  if (w_data_i[31]) begin
                     err_d = 1'b0;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
                     timeout_d = 1'b0;
`endif
                  end else if (|dirty_q) begin
                     state_d = S_FREEZE;
                  end else begin
                     done_d = 1'b1;
                  end
               end else if ((w_field_i == 2'd0) && (w_data_i >= 32'(num_cfgs_p))) begin
                  err_d = 1'b1;
               end else begin
                  dirty_d[w_ch_i] = 1'b1;
                  case (w_field_i)
                     2'd0:    shadow_d[w_ch_i].idx  = w_data_i[lg_max_cfgs_p-1:0];
                     2'd1:    shadow_d[w_ch_i].did  = w_data_i[did_width_p-1:0];
                     default: shadow_d[w_ch_i].cord = w_data_i[cord_width_p-1:0];
                  endcase
               end
            end
         end
         S_FREEZE: begin
            freeze_d = dirty_q;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
            cnt_d = '0;
`endif
            state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Drain wins over a timeout landing in the same cycle.
            if (&(idle_i | ~freeze_q)) begin
               state_d = S_APPLY;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
            end else if (cnt_q == cnt_w_lp'(timeout_p)) begin
               state_d = S_ABORT;
            end else begin
               cnt_d = cnt_q + 1'b1;
`endif
            end
         end
         S_APPLY: begin
            for (int i = 0; i < num_ch_p; i++) begin
               if (freeze_q[i]) begin
                  active_d[i] = shadow_q[i];
                  dirty_d[i]  = 1'b0;
               end
            end
            freeze_d = '0;
            done_d   = 1'b1;
            state_d  = S_IDLE;
         end
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
         S_ABORT: begin
            timeout_d = 1'b1;
            freeze_d  = '0;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= S_IDLE;
         dirty_q  <= '0;
         freeze_q <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         for (int i = 0; i < num_ch_p; i++) begin
            shadow_q[i] <= reset_cfg(i);
            active_q[i] <= reset_cfg(i);
         end
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         dirty_q  <= dirty_d;
         freeze_q <= freeze_d;
         done_q   <= done_d;
         err_q    <= err_d;
         shadow_q <= shadow_d;
         active_q <= active_d;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   always_comb begin
      cfg_idx_o = '0;
      did_o     = '0;
      cord_o    = '0;
      for (int i = 0; i < num_ch_p; i++) begin
         cfg_idx_o[i*lg_max_cfgs_p +: lg_max_cfgs_p] = active_q[i].idx;
         did_o[i*did_width_p +: did_width_p]          = active_q[i].did;
         cord_o[i*cord_width_p +: cord_width_p]       = active_q[i].cord;
      end
   end

   always_comb begin
      r_data_o = '0;
      case (r_field_i)
         2'd0:    r_data_o = 32'(active_q[r_ch_i].idx);
         2'd1:    r_data_o = 32'(active_q[r_ch_i].did);
         2'd2:    r_data_o = 32'(active_q[r_ch_i].cord);
         default: r_data_o = {30'd0, dirty_q[r_ch_i], err_q};
      endcase
   end

   assign w_ready_o     = (state_q == S_IDLE);
   assign busy_o        = (state_q != S_IDLE);
   assign freeze_o      = freeze_q;
   assign commit_done_o = done_q;
   assign err_o         = err_q;
   assign dbg_state_o   = state_q;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
   assign timeout_o = timeout_q;
`else
   assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_bp_cfg_commit_ctrl.sv
// Bench for bp_cfg_commit_ctrl: vector table of writes/readbacks plus commit corner sequences.
module tb_bp_cfg_commit_ctrl;
  localparam int NCH = 4;
  localparam int LGC = 3;
  localparam int DW  = 19;
  localparam int CW  = 8;
`ifdef BP_CFG_COMMIT_TIMEOUT_EN
  localparam int HOLD = 10;
`else
  localparam int HOLD = 20;
`endif

  logic              clk, reset_n;
  logic              w_v, w_ready;
  logic [1:0]        w_ch, w_field, r_ch, r_field;
  logic [31:0]       w_data, r_data;
  logic [NCH-1:0]    idle, freeze;
  logic [NCH*LGC-1:0] cfg_idx;
  logic [NCH*DW-1:0] did;
  logic [NCH*CW-1:0] cord;
  logic              busy, done, timeout, err;
  logic [2:0]        dbg_state;

  bp_cfg_commit_ctrl #(
    .num_ch_p(NCH), .lg_max_cfgs_p(LGC), .num_cfgs_p(3),
    .did_width_p(DW), .cord_width_p(CW), .timeout_p(15)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .w_v_i(w_v), .w_ready_o(w_ready),
    .w_ch_i(w_ch), .w_field_i(w_field), .w_data_i(w_data),
    .r_ch_i(r_ch), .r_field_i(r_field), .r_data_o(r_data),
    .idle_i(idle), .freeze_o(freeze), .cfg_idx_o(cfg_idx), .did_o(did),
    .cord_o(cord), .busy_o(busy), .commit_done_o(done), .timeout_o(timeout),
    .err_o(err), .dbg_state_o(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_q[$];

  typedef struct packed {
    logic [1:0]  ch;
    logic [1:0]  field;
    logic [31:0] data;
    logic [1:0]  rb_ch;
    logic [1:0]  rb_field;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic wr(input logic [1:0] ch, input logic [1:0] field, input logic [31:0] data);
    w_v = 1'b1; w_ch = ch; w_field = field; w_data = data;
    step();
    w_v = 1'b0;
  endtask

  task automatic rb(input string name, input logic [1:0] ch, input logic [1:0] field,
                    input logic [31:0] exp);
    exp_q.push_back(exp);
    r_ch = ch; r_field = field;
    #1;
    check(name, r_data, exp_q.pop_front());
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 200) begin step(); cyc++; end
    check("wait_idle", busy, 0);
  endtask

  task automatic wait_done(input int limit, output int cyc);
    cyc = 0;
    while (!done && cyc < limit) begin step(); cyc++; end
    check("done_seen", done, 1);
  endtask

  initial begin
    int cyc;
    int n_done;
    vecs[0]  = '{2'd0, 2'd0, 32'd5,          2'd0, 2'd3, 32'd1};
    vecs[1]  = '{2'd0, 2'd0, 32'd7,          2'd0, 2'd3, 32'd1};
    vecs[2]  = '{2'd0, 2'd3, 32'h8000_0000,  2'd0, 2'd3, 32'd0};
    vecs[3]  = '{2'd2, 2'd1, 32'h7FFFF,      2'd2, 2'd3, 32'd2};
    vecs[4]  = '{2'd2, 2'd2, 32'hAB,         2'd2, 2'd2, 32'd2};
    vecs[5]  = '{2'd2, 2'd0, 32'd1,          2'd2, 2'd0, 32'd0};
    vecs[6]  = '{2'd3, 2'd3, 32'd0,          2'd2, 2'd1, 32'h7FFFF};
    vecs[7]  = '{2'd1, 2'd3, 32'd0,          2'd2, 2'd2, 32'hAB};
    vecs[8]  = '{2'd1, 2'd1, 32'hFFFF_FFFF,  2'd1, 2'd3, 32'd2};
    vecs[9]  = '{2'd0, 2'd3, 32'd0,          2'd1, 2'd1, 32'h7FFFF};
    vecs[10] = '{2'd2, 2'd0, 32'd2,          2'd2, 2'd0, 32'd1};
    vecs[11] = '{2'd0, 2'd3, 32'd0,          2'd2, 2'd0, 32'd2};

    reset_n = 1'b0; w_v = 1'b0; w_ch = '0; w_field = '0; w_data = '0;
    r_ch = '0; r_field = '0; idle = 4'hF;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    // reset state
    rb("rst_cord_ch2", 2'd2, 2'd2, 32'd2);
    check("rst_cfg_idx", cfg_idx, 0);
    check("rst_did", did, 0);
    check("rst_cord", cord, 32'h03020100);
    check("rst_freeze", freeze, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", w_ready, 1);
    check("rst_flags", {done, timeout, err}, 0);
    check("rst_state", dbg_state, 0);

    // table-driven writes, commits and readbacks
    for (int i = 0; i < 12; i++) begin
      wr(vecs[i].ch, vecs[i].field, vecs[i].data);
      wait_idle();
      rb($sformatf("vec%0d", i), vecs[i].rb_ch, vecs[i].rb_field, vecs[i].exp);
    end

    // illegal cfg_idx, then commit with nothing dirty
    wr(2'd0, 2'd0, 32'd5);
    check("err_set", err, 1);
    rb("err_status", 2'd0, 2'd3, 32'd1);
    wr(2'd0, 2'd3, 32'd0);
    check("nodirty_done", done, 1);
    check("nodirty_busy", busy, 0);
    check("nodirty_freeze", freeze, 0);
    step();
    check("nodirty_done_drop", done, 0);
    wr(2'd0, 2'd3, 32'h8000_0000);
    check("clear_err", err, 0);
    check("clear_no_commit", {done, busy}, 0);

    // single-channel commit with cores idle
    wr(2'd1, 2'd0, 32'd2);
    wr(2'd0, 2'd3, 32'd0);
    n_done = 0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("t2_freeze_k%0d", k), freeze, (k == 1 || k == 2) ? 4'b0010 : 4'b0000);
      check($sformatf("t2_idx_k%0d", k), cfg_idx[5:3], (k >= 3) ? 3'd2 : 3'd0);
      if (done) n_done++;
      step();
    end
    check("t2_done_once", n_done, 1);

    // two-channel commit held off by a busy core, with a write stalled meanwhile
    wr(2'd0, 2'd1, 32'h5A5A);
    wr(2'd3, 2'd2, 32'd7);
    idle = 4'b0111;
    wr(2'd0, 2'd3, 32'd0);
    w_v = 1'b1; w_ch = 2'd2; w_field = 2'd1; w_data = 32'h123;
    for (int k = 0; k < HOLD; k++) begin
      step();
      check("t3_freeze", freeze, 4'b1001);
      check("t3_did_hold", did[18:0], 0);
      check("t3_cord_hold", cord[31:24], 3);
      check("t3_stall", {w_ready, busy}, 2'b01);
    end
    idle = 4'hF;
    step();
    check("t3_apply_did", did[18:0], 0);
    check("t3_apply_cord", cord[31:24], 3);
    step();
    check("t3_new_did", did[18:0], 19'h5A5A);
    check("t3_new_cord", cord[31:24], 7);
    check("t3_done", done, 1);
    check("t3_unfreeze", freeze, 0);
    step();
    w_v = 1'b0;
    rb("t3_stalled_dirty", 2'd2, 2'd3, 32'd2);
    rb("t3_ch0_clean", 2'd0, 2'd3, 32'd0);
    rb("t3_ch3_clean", 2'd3, 2'd3, 32'd0);
    wr(2'd0, 2'd3, 32'd0);
    wait_idle();
    rb("t3_stalled_applied", 2'd2, 2'd1, 32'h123);

`ifdef BP_CFG_COMMIT_TIMEOUT_EN
    // drain timeout -> abort, then a drain arriving on the timeout cycle
    wr(2'd1, 2'd1, 32'h11);
    idle = 4'h0;
    wr(2'd0, 2'd3, 32'd0);
    wait_done(40, cyc);
    check("to_latency", cyc, 18);
    check("to_flag", timeout, 1);
    check("to_did_kept", did[37:19], 19'h7FFFF);
    check("to_freeze", freeze, 0);
    rb("to_dirty_kept", 2'd1, 2'd3, 32'd2);
    wr(2'd0, 2'd3, 32'h8000_0000);
    check("to_clear", timeout, 0);
    wr(2'd1, 2'd1, 32'h22);
    wr(2'd0, 2'd3, 32'd0);
    step(16);
    check("tie_freeze", freeze, 4'b0010);
    idle = 4'hF;
    wait_done(10, cyc);
    check("tie_latency", cyc, 2);
    check("tie_no_timeout", timeout, 0);
    check("tie_did", did[37:19], 19'h22);
    rb("tie_clean", 2'd1, 2'd3, 32'd0);
`endif

    // asynchronous reset in DRAIN
    wr(2'd3, 2'd0, 32'd1);
    idle = 4'h0;
    wr(2'd0, 2'd3, 32'd0);
    step(3);
    check("ar_freeze_pre", freeze, 4'b1000);
    #2 reset_n = 1'b0;
    #1;
    check("ar_freeze", freeze, 0);
    check("ar_cfg_idx", cfg_idx, 0);
    check("ar_did", did, 0);
    check("ar_cord", cord, 32'h03020100);
    check("ar_flags", {busy, done, timeout, err}, 0);
    @(posedge clk);
    #3 reset_n = 1'b1;
    idle = 4'hF;
    step();
    check("ar_ready", w_ready, 1);
    rb("ar_dirty", 2'd3, 2'd3, 32'd0);
    rb("ar_cord_ch2", 2'd2, 2'd2, 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
